serial_adder: RTL and testbench

- Parametrised bit-serial add/subtract unit.
- Accepts two WIDTH-bit operands on a start strobe and processes one bit per clock through a single full-adder cell and a carry flop.
- Returns sum, carry-out and signed overflow with a one-cycle done pulse.
- Used as the area-minimal arithmetic engine in datapaths where latency is cheap and gates are not.

---
 rtl/serial_adder_pkg.sv | 31 +++
 rtl/serial_adder_full_adder_cell.sv | 24 ++
 rtl/serial_adder.sv | 134 +++++++++++++
 tb/tb_serial_adder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial add/subtract unit.
//   - state_t : FSM state encoding (2-bit binary). S_IDLE=2'd0, S_RUN=2'd1,
//               S_DONE=2'd2. The 2'b11 code is unused and is treated as
//               illegal by the FSM, which recovers to S_IDLE.
//   - cnt_width() : width of the bit counter for a given operand width.
//   - majority3() : carry function of a full adder.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // The counter needs to reach WIDTH-1; one spare bit keeps the compare
  // unambiguous for power-of-two widths.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  function automatic logic majority3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// -----------------------------------------------------------------------------
// full_adder_cell
//   Single-bit combinational full adder used as the only arithmetic cell of
//   the serial adder.
//   Ports:
//     x, y  : input  operand bits
//     cin   : input  carry in
//     s     : output sum bit  (x ^ y ^ cin)
//     cout  : output carry out (majority of x, y, cin)
// -----------------------------------------------------------------------------
module full_adder_cell
  import serial_adder_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = majority3(x, y, cin);

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial add/subtract unit. Operands are latched on a start strobe and
//   processed LSB first, one bit per clock, through a single full adder and a
//   carry flop. An operation takes WIDTH RUN cycles followed by one DONE cycle;
//   a start seen in DONE launches the next operation with no idle gap.
//
//   Handshake: start is a single-cycle request that is only looked at while
//   the unit is not busy (state IDLE or DONE); a, b and sub are captured on
//   that same edge and may change freely afterwards. busy is high for exactly
//   the WIDTH RUN cycles, done is high for the one DONE cycle, and sum/cout/ovf
//   are valid from the DONE cycle until the next operation completes.
//
//   Parameters:
//     WIDTH : operand/result width, 2..32
//   Ports:
//     clk   : input  rising-edge clock
//     rst   : input  asynchronous active-high reset
//     start : input  request strobe
//     sub   : input  0 = a+b, 1 = a-b
//     a, b  : input  operands [WIDTH-1:0]
//     busy  : output high while computing
//     done  : output one-cycle completion pulse
//     sum   : output result [WIDTH-1:0]
//     cout  : output carry out of MSB (for subtract, 1 = no borrow)
//     ovf   : output signed overflow
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] part;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] part_next;
  logic             last_bit;

  // The single arithmetic cell always looks at the current LSBs.
  full_adder_cell u_fa (
    .x    (op_a[0]),
    .y    (op_b[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  // Result bits enter at the MSB so that after WIDTH shifts the first
  // computed bit (the LSB) has reached position 0.
  assign part_next = {fa_s, part[WIDTH-1:1]};
  assign last_bit  = (cnt == LAST_BIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      op_a  <= '0;
      op_b  <= '0;
      part  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction as a + ~b + 1: invert b and seed the carry with 1.
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            part  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

        S_RUN: begin
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= fa_c;
          part  <= part_next;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            // On the MSB, 'carry' still holds the carry into the MSB.
            sum   <= part_next;
            cout  <= fa_c;
            ovf   <= carry ^ fa_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        default: begin
          // Unused 2'b11 code: recover quietly.
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int W = 8;
  localparam int TIMEOUT = 40;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int errors = 0;
  int checks = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vsub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[12];

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one operation and wait for done. Start is presented for exactly
  // one edge. Inputs are driven at the falling edge; outputs sampled there too.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                       output int edges, output int busy_cycles, output bit got_done);
    @(negedge clk);
    a = ta; b = tb_v; sub = ts; start = 1'b1;
    @(posedge clk);           // start edge
    #1 start = 1'b0;
    a = ~ta; b = ~tb_v; sub = ~ts;   // operands are not used after capture
    edges = 0; busy_cycles = 0; got_done = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
    end
  endtask

  task automatic op_and_check(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                              input logic ts, input logic [W-1:0] es, input logic ec, input logic eo);
    int  edges, bc;
    bit  got;
    do_op(ta, tb_v, ts, edges, bc, got);
    check({name, "_done_seen"}, 32'(got), 32'd1);
    check({name, "_sum"}, 32'(sum), 32'(es));
    check({name, "_cout"}, 32'(cout), 32'(ec));
    check({name, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  // Independent reference: plain wide arithmetic plus sign-rule overflow.
  task automatic ref_model(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                           output logic [W-1:0] rs, output logic rc, output logic ro);
    logic [W:0] full;
    if (ts) full = {1'b0, ta} - {1'b0, tb_v};
    else    full = {1'b0, ta} + {1'b0, tb_v};
    rs = full[W-1:0];
    // For subtraction the carry out means "no borrow".
    rc = ts ? (ta >= tb_v) : full[W];
    if (ts) ro = (ta[W-1] != tb_v[W-1]) && (rs[W-1] != ta[W-1]);
    else    ro = (ta[W-1] == tb_v[W-1]) && (rs[W-1] != ta[W-1]);
  endtask

  initial begin
    int  edges, bc;
    bit  got;
    int  seen;
    logic [W-1:0] rs;
    logic rc, ro;
    logic [W-1:0] ra, rb;
    logic rsub;

    //                  a      b      sub   sum    cout  ovf
    vecs[0]  = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3]  = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4]  = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5]  = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[7]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[8]  = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[9]  = '{8'h3C, 8'hA5, 1'b0, 8'hE1, 1'b0, 1'b0};
    vecs[10] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[11] = '{8'h55, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};

    // ---------------- reset ----------------
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // ---------------- latency / busy length ----------------
    do_op(8'h0F, 8'h01, 1'b0, edges, bc, got);
    check("lat_done_seen", 32'(got), 32'd1);
    check("lat_edges_to_done", 32'(edges), 32'(W));
    check("lat_busy_cycles", 32'(bc), 32'(W));
    check("lat_sum", 32'(sum), 32'h10);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
    check("sum_held_idle", 32'(sum), 32'h10);

    // ---------------- table vectors ----------------
    for (int i = 0; i < 12; i++) begin
      op_and_check($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vsub,
                   vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
    end

    // ---------------- start held through RUN, back-to-back ----------------
    @(negedge clk);
    a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
    @(posedge clk);           // first start edge
    repeat (3) @(posedge clk);
    #1 a = 8'h40; b = 8'h01; sub = 1'b1;   // changed mid-RUN, start still high
    got = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    check("b2b_first_done", 32'(got), 32'd1);
    check("b2b_first_sum", 32'(sum), 32'h46);
    check("b2b_first_cout", 32'(cout), 32'd0);
    @(negedge clk);           // DONE edge accepted start: RUN immediately
    check("b2b_no_idle_busy", 32'(busy), 32'd1);
    check("b2b_no_idle_done", 32'(done), 32'd0);
    start = 1'b0;
    check("b2b_sum_held_run", 32'(sum), 32'h46);
    got = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    check("b2b_second_done", 32'(got), 32'd1);
    check("b2b_second_sum", 32'(sum), 32'h3F);
    check("b2b_second_cout", 32'(cout), 32'd1);
    check("b2b_second_ovf", 32'(ovf), 32'd0);

    // ---------------- async reset mid-RUN ----------------
    op_and_check("pre_rst", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_sum",  32'(sum),  32'd0);
    check("arst_cout", 32'(cout), 32'd0);
    check("arst_ovf",  32'(ovf),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("arst_no_done_no_busy", 32'(seen), 32'd0);
    op_and_check("post_rst", 8'h21, 8'h43, 1'b0, 8'h64, 1'b0, 1'b0);

    // ---------------- random sweep against reference ----------------
    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      rsub = 1'($urandom_range(0, 1));
      ref_model(ra, rb, rsub, rs, rc, ro);
      op_and_check($sformatf("rnd%0d", i), ra, rb, rsub, rs, rc, ro);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
